image_pixel_writer: RTL and testbench
=====================================

Name: image_pixel_writer

Overview:
- CPU-side writer for the RGB565 image framebuffer.
- The 8051 bus interface decodes an 8-bit register write window. The block assembles 16-bit RGB565 pixels from byte writes and commits them to the video RAM write port.
- Address auto-increments after each commit; the VGA image path reads that same framebuffer.
- Writes are arbitrated through a ready handshake, because video RAM is shared with the display read side.

Parameters:
- ADDR_W, 17, video RAM pixel address width.
- FRAME_PIXELS, 76800, number of valid pixel locations (320x240); addresses 0..FRAME_PIXELS-1.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_wr  input  1  CPU register write strobe, one cycle per write.
- i_reg  input  3  register select.
- i_data  input  8  CPU write data.
- o_vram_we  output  1  write request to video RAM, held until accepted.
- o_vram_addr  output  ADDR_W  pixel address of the pending write.
- o_vram_data  output  16  RGB565 pixel, {R[4:0],G[5:0],B[4:0]}.
- i_vram_ready  input  1  video RAM accepts the write this cycle when o_vram_we=1.
- o_busy  output  1  a write is pending (FSM in REQ).
- o_error  output  1  sticky: a commit was dropped (busy overrun or out-of-range address).

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_rst_n.
- Reset values:
  - o_vram_we=0, o_busy=0, o_error=0, o_vram_addr=0, o_vram_data=0.
  - Address pointer=0, pixel high byte=0, auto-increment enabled=1, FSM=IDLE.
- Register map (written when i_wr=1):
  - 0: ADDR[7:0].
  - 1: ADDR[15:8].
  - 2: ADDR[ADDR_W-1:16]; unused bits ignored.
  - 3: PIX_HI, latches i_data as pixel[15:8].
  - 4: PIX_LO, pixel[7:0]; this write is the commit.
  - 5: CTRL. Bit0=1 clears o_error. Bit1 sets the auto-increment enable.
  - 6, 7: ignored (see Optional Feature).
- FSM states:
  - IDLE: a commit with pointer < FRAME_PIXELS latches {PIX_HI,i_data} and the pointer into the output registers and moves to REQ. o_vram_we=1 the next cycle (latency 1).
  - REQ: o_vram_we=1 and the outputs are held stable until i_vram_ready=1.
  - On acceptance: the pointer increments if auto-increment is enabled, wrapping FRAME_PIXELS-1 to 0. The FSM returns to IDLE unless a back-to-back commit occurs in the same cycle.
- Back-to-back: a commit in the acceptance cycle is taken and uses the post-increment pointer; the FSM stays in REQ with the new data and address.
- Overrun: a commit while in REQ and not in the acceptance cycle is dropped and sets o_error. The pending write is unaffected.
- Out of range: a commit with pointer >= FRAME_PIXELS is dropped, sets o_error, and does not increment the pointer.
- Address write during REQ: updates the pointer only; the in-flight o_vram_addr is unchanged. If it coincides with acceptance, the CPU write wins over auto-increment.
- CTRL clear and an error event in the same cycle: the error wins (o_error=1).
- Reset mid-REQ: the pending write is abandoned and o_vram_we drops immediately (asynchronous).
- o_busy is registered and equals (state==REQ).

Optional Feature:
- Macro: IMAGE_PIXEL_WRITER_RGB888_EN.
- When defined:
  - Reg 3 latches R and reg 4 latches G; neither commits.
  - Reg 6 = B and is the commit.
  - Packed pixel = {R[7:3],G[7:2],B[7:3]}.
  - All commit and error rules apply to reg 6.
- When undefined: RGB565 byte mode as above; reg 6 is ignored.

Decomposition:
- Shared package image_pkg holds:
  - register index constants (REG_ADDR0..REG_B);
  - CTRL bit positions;
  - FSM state enum (IDLE, REQ);
  - FRAME_PIXELS default;
  - RGB565 field widths (5/6/5), shared with the display-side decoder.
- One sub-module: rgb888_to_rgb565, a combinational pack function. It is instantiated only under the macro.

Test Plan:
- Reset, then write ADDR=0x00010 and PIX_HI=0xF8, PIX_LO=0x00, with i_vram_ready=1 -> o_vram_we for 1 cycle with addr 0x00010, data 0xF800; pointer becomes 0x00011.
- i_vram_ready held 0 for 5 cycles after a commit -> o_vram_we, addr and data stable for 5 cycles and o_busy=1. Release ready -> one write, then IDLE.
- Second commit during a stalled REQ -> dropped and o_error=1; the original data is still written. CTRL=0x03 -> o_error=0.
- ADDR=76799, commit 0x07E0 twice with ready=1 -> writes at 76799 then 0; a commit at ADDR=76800 is dropped and o_error=1.
- Commit in the acceptance cycle of the previous write -> back-to-back writes at N and N+1; o_vram_we never deasserts.
- With IMAGE_PIXEL_WRITER_RGB888_EN: R=0xFF, G=0x80, B=0x08 -> data 0xFC01. Assert i_rst_n=0 mid-REQ -> o_vram_we=0 immediately.

Source files
------------

// File: rtl/image_pkg.sv
// Shared constants for the RGB565 framebuffer writer and display path.
// Register map, CTRL bits, FSM states and pixel field widths.
package image_pkg;

  localparam int FRAME_PIXELS_DEF = 76800;

  localparam logic [2:0] REG_ADDR0  = 3'd0;
  localparam logic [2:0] REG_ADDR1  = 3'd1;
  localparam logic [2:0] REG_ADDR2  = 3'd2;
  localparam logic [2:0] REG_PIX_HI = 3'd3;
  localparam logic [2:0] REG_PIX_LO = 3'd4;
  localparam logic [2:0] REG_CTRL   = 3'd5;
  localparam logic [2:0] REG_R      = 3'd3;
  localparam logic [2:0] REG_G      = 3'd4;
  localparam logic [2:0] REG_B      = 3'd6;

  localparam int CTRL_CLR_ERR  = 0;
  localparam int CTRL_AUTO_INC = 1;

  localparam int R_W = 5;
  localparam int G_W = 6;
  localparam int B_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

endpackage

// File: rtl/rgb888_to_rgb565.sv
// Packs an 8:8:8 colour into RGB565 by keeping the channel MSBs.
// Pure combinational; used only in the RGB888 input mode.
module rgb888_to_rgb565
  import image_pkg::*;
(
  input  logic [7:0]  i_r,
  input  logic [7:0]  i_g,
  input  logic [7:0]  i_b,
  output logic [15:0] o_pix
);

  logic unused_lsbs;

  assign o_pix = {i_r[7:8-R_W],
                  i_g[7:8-G_W],
                  i_b[7:8-B_W]};

  assign unused_lsbs = ^{i_r[7-R_W:0],
                         i_g[7-G_W:0],
                         i_b[7-B_W:0]};

endmodule

// File: rtl/image_pixel_writer.sv
// CPU byte-register writer that commits RGB565 pixels to video RAM.
// Optional macro IMAGE_PIXEL_WRITER_RGB888_EN: R/G/B regs, B commits.
module image_pixel_writer
  import image_pkg::*;
#(
  parameter int ADDR_W       = 17,
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr,
  input  logic [2:0]        i_reg,
  input  logic [7:0]        i_data,
  output logic              o_vram_we,
  output logic [ADDR_W-1:0] o_vram_addr,
  output logic [15:0]       o_vram_data,
  input  logic              i_vram_ready,
  output logic              o_busy,
  output logic              o_error
);

  localparam logic [ADDR_W:0] FRAME_N =
    (ADDR_W+1)'(FRAME_PIXELS);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(FRAME_PIXELS - 1);

`ifdef IMAGE_PIXEL_WRITER_RGB888_EN
  localparam logic [2:0] COMMIT_REG = REG_B;
`else
  localparam logic [2:0] COMMIT_REG = REG_PIX_LO;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic [7:0]        hi_q, hi_d;
  logic              auto_q, auto_d;
  logic              err_q, err_d;

  logic [15:0]       pix;
  logic [ADDR_W-1:0] ptr_inc;
  logic [ADDR_W-1:0] ptr_cur;
  logic              accept;
  logic              commit;
  logic              err_set;
  logic              err_clr;

`ifdef IMAGE_PIXEL_WRITER_RGB888_EN
  logic [7:0] g_q, g_d;

  rgb888_to_rgb565 u_pack (
    .i_r   (hi_q),
    .i_g   (g_q),
    .i_b   (i_data),
    .o_pix (pix)
  );
`else
  assign pix = {hi_q, i_data};
`endif

  assign ptr_inc = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
  assign accept  = (state_q == REQ) && i_vram_ready;
  assign commit  = i_wr && (i_reg == COMMIT_REG);
  assign ptr_cur = (accept && auto_q) ? ptr_inc : ptr_q;

  // Next-state: acceptance, register writes, commit and error rules.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    hi_d    = hi_q;
    auto_d  = auto_q;
    err_set = 1'b0;
    err_clr = 1'b0;
`ifdef IMAGE_PIXEL_WRITER_RGB888_EN
    g_d     = g_q;
`endif
    if (accept) begin
      state_d = IDLE;
      if (auto_q) ptr_d = ptr_inc;
    end
    if (i_wr) begin
      case (i_reg)
        REG_ADDR0: begin
          ptr_d       = ptr_q;
          ptr_d[7:0]  = i_data;
        end
        REG_ADDR1: begin
          ptr_d       = ptr_q;
          ptr_d[15:8] = i_data;
        end
        REG_ADDR2: begin
          ptr_d = ptr_q;
          ptr_d[ADDR_W-1:16] = i_data[ADDR_W-17:0];
        end
        REG_PIX_HI: hi_d = i_data;
`ifdef IMAGE_PIXEL_WRITER_RGB888_EN
        REG_G: g_d = i_data;
`endif
        REG_CTRL: begin
          err_clr = i_data[CTRL_CLR_ERR];
          auto_d  = i_data[CTRL_AUTO_INC];
        end
        default: ;
      endcase
    end
    if (commit) begin
      if ((state_q == IDLE || accept) &&
          ({1'b0, ptr_cur} < FRAME_N)) begin
        addr_d  = ptr_cur;
        data_d  = pix;
        state_d = REQ;
      end else begin
        err_set = 1'b1;
      end
    end
    err_d = (err_q && !err_clr) || err_set;
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      hi_q    <= '0;
      auto_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      hi_q    <= hi_d;
      auto_q  <= auto_d;
      err_q   <= err_d;
    end
  end

`ifdef IMAGE_PIXEL_WRITER_RGB888_EN
  // Green channel holding register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) g_q <= '0;
    else          g_q <= g_d;
  end
`endif

  assign o_vram_we   = (state_q == REQ);
  assign o_busy      = (state_q == REQ);
  assign o_vram_addr = addr_q;
  assign o_vram_data = data_q;
  assign o_error     = err_q;

endmodule

// File: tb/tb_image_pixel_writer.sv
// Self-checking bench for image_pixel_writer.
// Scoreboard queue of expected VRAM writes plus directed sequences.
module tb_image_pixel_writer;
  import image_pkg::*;

`ifdef IMAGE_PIXEL_WRITER_RGB888_EN
  localparam logic [2:0] COMMIT = REG_B;
`else
  localparam logic [2:0] COMMIT = REG_PIX_LO;
`endif

  logic        clk;
  logic        rst_n;
  logic        i_wr;
  logic [2:0]  i_reg;
  logic [7:0]  i_data;
  logic        we;
  logic [16:0] addr;
  logic [15:0] data;
  logic        ready;
  logic        busy;
  logic        err;

  typedef struct {
    logic [16:0] a;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    logic [16:0] ptr;
    logic [15:0] px;
  } vec_t;

  wr_t  q[$];
  vec_t tv[4];
  int   total = 0;
  int   bad   = 0;

  image_pixel_writer dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_wr         (i_wr),
    .i_reg        (i_reg),
    .i_data       (i_data),
    .o_vram_we    (we),
    .o_vram_addr  (addr),
    .o_vram_data  (data),
    .i_vram_ready (ready),
    .o_busy       (busy),
    .o_error      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h",
               nm, act, exp);
    end
  endtask

  // Scoreboard: every accepted write must match the queue head.
  always @(negedge clk) begin
    if (rst_n && we && ready) begin
      if (q.size() == 0) begin
        chk("unexpected_write", {15'd0, addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = q.pop_front();
        chk("wr_addr", {15'd0, addr}, {15'd0, e.a});
        chk("wr_data", {16'd0, data}, {16'd0, e.d});
      end
    end
  end

  function automatic logic [15:0] exp_px(input logic [7:0] a,
                                         input logic [7:0] g,
                                         input logic [7:0] b);
`ifdef IMAGE_PIXEL_WRITER_RGB888_EN
    return {a[7:3], g[7:2], b[7:3]};
`else
    return {a, b};
`endif
  endfunction

  function automatic logic [16:0] nxt(input logic [16:0] p);
    return (p == 17'd76799) ? 17'd0 : p + 17'd1;
  endfunction

  task automatic wr(input logic [2:0] r, input logic [7:0] d);
    i_wr   = 1'b1;
    i_reg  = r;
    i_data = d;
    @(posedge clk);
    #1;
    i_wr = 1'b0;
  endtask

  task automatic set_addr(input logic [16:0] a);
    wr(REG_ADDR0, a[7:0]);
    wr(REG_ADDR1, a[15:8]);
    wr(REG_ADDR2, {7'd0, a[16]});
  endtask

  task automatic put_pix(input logic [15:0] px);
`ifdef IMAGE_PIXEL_WRITER_RGB888_EN
    wr(REG_R, {px[15:11], 3'b0});
    wr(REG_G, {px[10:5], 2'b0});
    wr(REG_B, {px[4:0], 3'b0});
`else
    wr(REG_PIX_HI, px[15:8]);
    wr(REG_PIX_LO, px[7:0]);
`endif
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk(nm, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    logic [16:0] n;
    logic [15:0] e1, e2;

    tv[0] = '{17'h00010, 16'hF800};
    tv[1] = '{17'h00000, 16'h001F};
    tv[2] = '{17'h0ABCD, 16'h1234};
    tv[3] = '{17'd76799, 16'h07E0};

    rst_n  = 1'b0;
    i_wr   = 1'b0;
    i_reg  = 3'd0;
    i_data = 8'd0;
    ready  = 1'b1;
    #22;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_we",   {31'd0, we},   32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err",  {31'd0, err},  32'd0);
    chk("rst_addr", {15'd0, addr}, 32'd0);
    chk("rst_data", {16'd0, data}, 32'd0);

    // Table: write at ptr, then a second write at the auto-incremented ptr.
    for (int i = 0; i < 4; i++) begin
      set_addr(tv[i].ptr);
      put_pix(tv[i].px);
      q.push_back('{tv[i].ptr, tv[i].px});
      chk("lat1_we", {31'd0, we}, 32'd1);
      wait_idle("tbl_idle_a");
      put_pix(~tv[i].px);
      q.push_back('{nxt(tv[i].ptr), ~tv[i].px});
      wait_idle("tbl_idle_b");
      chk("tbl_we_low", {31'd0, we}, 32'd0);
    end

    // Stall for 5 cycles, then an overrun commit.
    ready = 1'b0;
    set_addr(17'h00200);
    put_pix(16'hBEEF);
    q.push_back('{17'h00200, 16'hBEEF});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_we",   {31'd0, we},   32'd1);
      chk("stall_busy", {31'd0, busy}, 32'd1);
      chk("stall_addr", {15'd0, addr}, 32'h200);
      chk("stall_data", {16'd0, data}, 32'hBEEF);
    end
    @(posedge clk);
    #1;
    wr(COMMIT, 8'h55);
    chk("ovr_err",  {31'd0, err},  32'd1);
    chk("ovr_data", {16'd0, data}, 32'hBEEF);
    ready = 1'b1;
    wait_idle("stall_idle");
    chk("stall_busy0", {31'd0, busy}, 32'd0);
    chk("err_sticky",  {31'd0, err},  32'd1);
    wr(REG_CTRL, 8'h03);
    chk("err_clr", {31'd0, err}, 32'd0);

    // Out-of-range commit is dropped.
    set_addr(17'd76800);
    put_pix(16'h07E0);
    chk("oor_err", {31'd0, err}, 32'd1);
    @(negedge clk);
    chk("oor_we", {31'd0, we}, 32'd0);
    @(posedge clk);
    #1;
    wr(REG_CTRL, 8'h03);
    chk("oor_clr", {31'd0, err}, 32'd0);

    // Back-to-back commits: second lands in acceptance cycle.
    n = 17'h00300;
    set_addr(n);
`ifdef IMAGE_PIXEL_WRITER_RGB888_EN
    wr(REG_R, 8'hA8);
    wr(REG_G, 8'h54);
`else
    wr(REG_PIX_HI, 8'hA8);
`endif
    e1 = exp_px(8'hA8, 8'h54, 8'h18);
    e2 = exp_px(8'hA8, 8'h54, 8'hE0);
    q.push_back('{n, e1});
    q.push_back('{n + 17'd1, e2});
    wr(COMMIT, 8'h18);
    wr(COMMIT, 8'hE0);
    chk("b2b_we",   {31'd0, we},   32'd1);
    chk("b2b_addr", {15'd0, addr}, {15'd0, n + 17'd1});
    chk("b2b_err",  {31'd0, err},  32'd0);
    wait_idle("b2b_idle");

    // Address write coinciding with acceptance wins.
    ready = 1'b0;
    set_addr(17'h00020);
    put_pix(16'h1111);
    q.push_back('{17'h00020, 16'h1111});
    ready = 1'b1;
    wr(REG_ADDR0, 8'h40);
    wait_idle("aw_idle");
    put_pix(16'h2222);
    q.push_back('{17'h00040, 16'h2222});
    wait_idle("aw_idle2");

    // Auto-increment disabled: same address twice.
    wr(REG_CTRL, 8'h00);
    set_addr(17'h00005);
    put_pix(16'h0F0F);
    q.push_back('{17'h00005, 16'h0F0F});
    wait_idle("noinc_a");
    put_pix(16'hF0F0);
    q.push_back('{17'h00005, 16'hF0F0});
    wait_idle("noinc_b");
    wr(REG_CTRL, 8'h02);

`ifdef IMAGE_PIXEL_WRITER_RGB888_EN
    set_addr(17'h00400);
    wr(REG_R, 8'hFF);
    wr(REG_G, 8'h80);
    wr(REG_B, 8'h08);
    q.push_back('{17'h00400, 16'hFC01});
    wait_idle("rgb_idle");
`endif

    // Asynchronous reset mid-REQ drops the request at once.
    ready = 1'b0;
    set_addr(17'h00050);
    put_pix(16'hAAAA);
    chk("pre_rst_we", {31'd0, we}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_we",   {31'd0, we},   32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready = 1'b1;
    @(posedge clk);
    #1;
    put_pix(16'h3333);
    q.push_back('{17'h00000, 16'h3333});
    wait_idle("post_rst_idle");

    chk("queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
